// File: rtl/flopr_pkg.sv
// rtl/flopr_pkg.sv - shared defaults and width helper for the pipeline register
package flopr_pkg;

    localparam int FLOPR_W     = 64;
    localparam int FLOPR_DEPTH = 4;

    // Width of a counter that must hold every value from 0 to depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flopr_pipe_if.sv
// rtl/flopr_pipe_if.sv - data/control bundle between a pipeline producer and flopr_pipe
interface flopr_pipe_if
    import flopr_pkg::*;
#(
    parameter int N     = FLOPR_W,
    parameter int DEPTH = FLOPR_DEPTH
);

    logic                      en;
    logic                      flush;
    logic [N-1:0]              d;
    logic                      d_valid;
    logic [N-1:0]              q;
    logic                      q_valid;
    logic [cnt_w(DEPTH)-1:0]   count;

    // Producer side: drives the stage-0 entry and the pipe controls
    modport master (
        output en, flush, d, d_valid,
        input  q, q_valid, count
    );

    // Pipeline register side
    modport slave (
        input  en, flush, d, d_valid,
        output q, q_valid, count
    );

endinterface

// File: rtl/flopr_en.sv
// rtl/flopr_en.sv - one resettable, clearable, enabled register stage
module flopr_en #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // reset beats clear beats advance; otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/flopr_pipe.sv
// rtl/flopr_pipe.sv - DEPTH-stage pipeline register with per-stage valid and occupancy count
module flopr_pipe
    import flopr_pkg::*;
#(
    parameter int N     = FLOPR_W,
    parameter int DEPTH = FLOPR_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    flopr_pipe_if.slave  bus
);

    localparam int CW = cnt_w(DEPTH);

    // Each stage stores {valid, data} so bubbles travel alongside their data
    logic [N:0]       stage_q [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [CW-1:0]    count_r;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [N:0] stage_d;

        if (k == 0) begin : g_head
            assign stage_d = {bus.d_valid, bus.d};
        end else begin : g_body
            assign stage_d = stage_q[k-1];
        end

        flopr_en #(.N(N + 1)) u_stage (
            .clk   (clk),
            .reset (reset),
            .clr   (bus.flush),
            .en    (bus.en),
            .d     (stage_d),
            .q     (stage_q[k])
        );

        assign vld[k] = stage_q[k][N];
    end

    // Occupancy tracked incrementally: one entry in, the oldest out, per enabled edge
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (bus.flush) begin
            count_r <= '0;
        end else if (bus.en) begin
            count_r <= count_r + CW'(bus.d_valid) - CW'(vld[DEPTH-1]);
        end
    end

    assign bus.q       = stage_q[DEPTH-1][N-1:0];
    assign bus.q_valid = vld[DEPTH-1];
    assign bus.count   = count_r;

    // The incremental counter must always agree with the live valid bits
    property p_count_matches_valids;
        @(posedge clk) disable iff (reset) count_r == CW'($countones(vld));
    endproperty
    a_count_matches_valids: assert property (p_count_matches_valids);

endmodule

// File: tb/tb_flopr_pipe.sv
// tb/tb_flopr_pipe.sv - scoreboard bench for flopr_pipe at DEPTH=4 and DEPTH=1
module tb_flopr_pipe;

    logic clk;
    logic reset;

    flopr_pipe_if #(.N(64), .DEPTH(4)) bus_a ();
    flopr_pipe_if #(.N(64), .DEPTH(1)) bus_b ();

    flopr_pipe #(.N(64), .DEPTH(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    flopr_pipe #(.N(64), .DEPTH(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        v;
    } ent_t;

    typedef struct {
        logic [63:0] q;
        logic        qv;
        int          cnt;
    } exp_t;

    // Reference pipes: front = newest entry, back = oldest (the one on q)
    ent_t ma[$];
    ent_t mb[$];
    exp_t ea[$];
    exp_t eb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input ent_t m[$]);
        exp_t x;
        x.q   = m[m.size()-1].data;
        x.qv  = m[m.size()-1].v;
        x.cnt = 0;
        foreach (m[i]) x.cnt += int'(m[i].v);
        return x;
    endfunction

    // Drive one cycle of stimulus and advance both reference pipes
    task automatic step(input bit r, input bit fl, input bit e, input logic [63:0] dd, input bit dv);
        @(negedge clk);
        reset         = r;
        bus_a.flush   = fl;
        bus_a.en      = e;
        bus_a.d       = dd;
        bus_a.d_valid = dv;
        bus_b.flush   = fl;
        bus_b.en      = e;
        bus_b.d       = dd;
        bus_b.d_valid = dv;
        if (r || fl) begin
            ma = {};
            mb = {};
            for (int i = 0; i < 4; i++) ma.push_back('{data: 64'h0, v: 1'b0});
            mb.push_back('{data: 64'h0, v: 1'b0});
        end else if (e && ma.size() != 0) begin
            ma.push_front('{data: dd, v: dv});
            void'(ma.pop_back());
            mb.push_front('{data: dd, v: dv});
            void'(mb.pop_back());
        end
        if (ma.size() != 0) begin
            ea.push_back(mk(ma));
            eb.push_back(mk(mb));
        end
    endtask

    // Monitors: one expected response per clock edge, checked just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ea.size() > 0) begin
            e = ea.pop_front();
            chk("a_q",       bus_a.q,                e.q);
            chk("a_q_valid", 64'(bus_a.q_valid),     64'(e.qv));
            chk("a_count",   64'(bus_a.count),       64'(e.cnt));
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (eb.size() > 0) begin
            e = eb.pop_front();
            chk("b_q",       bus_b.q,                e.q);
            chk("b_q_valid", 64'(bus_b.q_valid),     64'(e.qv));
            chk("b_count",   64'(bus_b.count),       64'(e.cnt));
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset         = 1'b1;
        bus_a.flush   = 1'b0;
        bus_a.en      = 1'b0;
        bus_a.d       = '0;
        bus_a.d_valid = 1'b0;
        bus_b.flush   = 1'b0;
        bus_b.en      = 1'b0;
        bus_b.d       = '0;
        bus_b.d_valid = 1'b0;

        // Reset held with live inputs must keep everything cleared
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b1);

        // Six valid words fill the pipe; count saturates at DEPTH
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 1'b1, 64'hA000_0000_0000_0000 + 64'(i), 1'b1);
        after_edge();
        chk("fill_count", 64'(bus_a.count), 64'd4);
        chk("fill_q",     bus_a.q,           64'hA000_0000_0000_0003);

        // Stall while d toggles, then resume
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, {$urandom, $urandom}, i[0]);
        for (int i = 7; i <= 10; i++) step(1'b0, 1'b0, 1'b1, 64'hA000_0000_0000_0000 + 64'(i), 1'b1);

        // Flush with en high on a full pipe, then refill from empty
        step(1'b0, 1'b1, 1'b1, 64'hFFFF, 1'b1);
        after_edge();
        chk("flush_count",   64'(bus_a.count),   64'd0);
        chk("flush_q_valid", 64'(bus_a.q_valid), 64'd0);
        step(1'b0, 1'b0, 1'b1, 64'h1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 64'h2 + 64'(i), 1'b0);
        after_edge();
        chk("refill_q",     bus_a.q,            64'h1);
        chk("refill_count", 64'(bus_a.count),   64'd1);

        // Alternating bubbles
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, {$urandom, $urandom}, ~i[0]);
        after_edge();
        chk("bubble_count", 64'(bus_a.count), 64'd2);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7,
                 {$urandom, $urandom},
                 1'($urandom));
        end

        after_edge();
        after_edge();
        chk("drain_a", 64'(ea.size()), 64'd0);
        chk("drain_b", 64'(eb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
